// File: rtl/biss_crc_engine.sv
// Table-free MSB-first CRC engine for BiSS-C frames. Consumes BITS_PER_CYC payload
// bits per clock, optionally inverts the result and compares it with the received CRC.
//
// state | meaning
// IDLE  | waiting for start; latches payload, length and received CRC
// CALC  | folds up to BITS_PER_CYC payload bits per cycle into the CRC register
// FIN   | publishes crc_out/crc_ok, pulses done, drops busy
module biss_crc_engine #(
    parameter int                       DATA_W       = 32,
    parameter int                       CRC_W        = 6,
    parameter logic [CRC_W-1:0]         POLY         = 6'h03,
    parameter logic [CRC_W-1:0]         INIT         = '0,
    parameter int                       BITS_PER_CYC = 6,
    parameter bit                       OUT_INV      = 1'b1,
    parameter int                       LEN_W        = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [CRC_W-1:0]  crc_rx,
    output logic              busy,
    output logic              done,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] DATA_W_L = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] STEP_L   = LEN_W'(BITS_PER_CYC);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic [CRC_W-1:0]   rx_q, rx_nxt;
    logic [CRC_W-1:0]   crc_q, crc_nxt;
    logic [LEN_W-1:0]   rem_q, rem_nxt;
    logic               busy_nxt, done_nxt, crc_ok_nxt;
    logic [CRC_W-1:0]   crc_out_nxt;

    logic [LEN_W-1:0]   len_clamp;
    logic [CRC_W-1:0]   crc_step;
    logic [CRC_W-1:0]   crc_fin;
    logic               fb;

    assign len_clamp = (data_len > DATA_W_L) ? DATA_W_L : data_len;
    assign crc_fin   = OUT_INV ? ~crc_q : crc_q;

    // Payload is stored left-aligned so the next bit to send is always the MSB;
    // rem_q counts bits still to fold and masks the tail of a partial chunk.
    always_comb begin
        crc_step = crc_q;
        fb       = 1'b0;
        for (int k = 0; k < BITS_PER_CYC; k++) begin
            if (LEN_W'(k) < rem_q) begin
                fb       = crc_step[CRC_W-1] ^ data_q[DATA_W-1-k];
                crc_step = {crc_step[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        data_nxt    = data_q;
        rx_nxt      = rx_q;
        crc_nxt     = crc_q;
        rem_nxt     = rem_q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        crc_out_nxt = crc_out;
        crc_ok_nxt  = crc_ok;
        case (state)
            IDLE: begin
                if (start) begin
                    data_nxt  = data_in << (DATA_W_L - len_clamp);
                    rx_nxt    = crc_rx;
                    rem_nxt   = len_clamp;
                    crc_nxt   = INIT;
                    busy_nxt  = 1'b1;
                    state_nxt = (len_clamp == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                crc_nxt  = crc_step;
                data_nxt = data_q << BITS_PER_CYC;
                rem_nxt  = rem_q - STEP_L;
                if (rem_q <= STEP_L) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                crc_out_nxt = crc_fin;
                crc_ok_nxt  = (crc_fin == rx_q);
                done_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            rx_q    <= '0;
            crc_q   <= INIT;
            rem_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            rx_q    <= rx_nxt;
            crc_q   <= crc_nxt;
            rem_q   <= rem_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            crc_out <= crc_out_nxt;
            crc_ok  <= crc_ok_nxt;
        end
    end

endmodule
